seq_shift_add_multiplier: RTL

Parametrised sequential shift-add multiplier: control FSM, iteration counter and datapath (accumulator, carry/sign bit X, multiplier shift register, multiplicand latch) in one block. Computes a WIDTH x WIDTH product into 2*WIDTH bits in a fixed 2*WIDTH+1 cycles, with a Start/Busy/Done handshake. Optional two's-complement mode replaces the fixed 8-bit signed-only multiplier control in the arithmetic unit.

---
 rtl/seq_shift_add_multiplier_if.sv | 54 +++++
 rtl/seq_shift_add_multiplier.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier_if.sv
// -----------------------------------------------------------------------------
// seq_shift_add_multiplier_if
//
// Purpose: bundles the request/response signals of the sequential shift-add
// multiplier so requester and multiplier connect through a single port.
//
// Handshake: the requester raises Start together with A, B and Signed_Mode.
// The multiplier accepts on the first rising edge where it is idle and Start
// is high. The operands are captured on that edge and may change afterwards.
// Busy is high while the multiplication runs. Done is a single-cycle pulse
// marking Product as valid. Product holds its value until the next accepted
// Start completes. Start seen while busy or in the Done cycle is dropped, not
// queued.
//
// Signals:
//   Start        requester -> multiplier  request strobe
//   Signed_Mode  requester -> multiplier  1 = two's-complement operands
//   A            requester -> multiplier  multiplicand (WIDTH bits)
//   B            requester -> multiplier  multiplier   (WIDTH bits)
//   Busy         multiplier -> requester  operation in progress
//   Done         multiplier -> requester  one-cycle completion pulse
//   Product      multiplier -> requester  2*WIDTH-bit result
// -----------------------------------------------------------------------------
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                   Start;
    logic                   Signed_Mode;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   Busy;
    logic                   Done;
    logic [2*WIDTH-1:0]     Product;

    modport master (
        output Start,
        output Signed_Mode,
        output A,
        output B,
        input  Busy,
        input  Done,
        input  Product
    );

    modport slave (
        input  Start,
        input  Signed_Mode,
        input  A,
        input  B,
        output Busy,
        output Done,
        output Product
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// seq_shift_add_multiplier
//
// Purpose: sequential shift-add multiplier. Computes a WIDTH x WIDTH product
// into 2*WIDTH bits. It runs one ADD cycle and one SHIFT cycle per multiplier
// bit, so an operation always takes the same number of cycles. Control FSM,
// iteration counter and datapath are all in this module.
//
// Configuration macro: MULT_SIGNED_EN
//   defined     - Signed_Mode selects two's-complement operation.
//   not defined - Signed_Mode is ignored. Every operation is unsigned and the
//                 subtract path is not built. The ports are the same in both
//                 builds.
//
// Parameters:
//   WIDTH        operand width, 2..32
//
// Ports:
//   Clk          clock, rising edge
//   Reset        synchronous, active-high; aborts any operation, clears Product
//   bus          seq_shift_add_multiplier_if.slave (Start/Signed_Mode/A/B in,
//                Busy/Done/Product out)
//   dbg_state_o  current FSM state, encoded as state_t below
// -----------------------------------------------------------------------------
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                        Clk,
    input  logic                        Reset,
    seq_shift_add_multiplier_if.slave   bus,
    output logic [1:0]                  dbg_state_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    // Encoding: IDLE=0, ADD=1, SHIFT=2, DONE=3
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic [WIDTH-1:0]       q_q, q_d;
    logic                   x_q, x_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sgn_q, sgn_d;
    logic [2*WIDTH-1:0]     product_q, product_d;

    logic                   busy;
    logic                   done;
    logic                   signed_sel;
    logic [WIDTH:0]         ext_acc;
    logic [WIDTH:0]         ext_mcand;
    logic [WIDTH:0]         add_res;

    // ------------------------------------------------------------------
    // Arithmetic unit
    // ------------------------------------------------------------------
    // Both operands are widened by one bit so the carry (unsigned) or the
    // true sign (signed) ends up in X. Without that bit, -2^(W-1) squared
    // would not fit.
    always_comb begin
        ext_acc   = sgn_q ? {acc_q[WIDTH-1], acc_q}     : {1'b0, acc_q};
        ext_mcand = sgn_q ? {mcand_q[WIDTH-1], mcand_q} : {1'b0, mcand_q};
    end

`ifdef MULT_SIGNED_EN
    // In two's complement the multiplier MSB has weight -2^(W-1). On the
    // last iteration the multiplicand is therefore subtracted, not added.
    always_comb begin
        if (sgn_q && (cnt_q == LAST_CNT)) begin
            add_res = ext_acc - ext_mcand;
        end else begin
            add_res = ext_acc + ext_mcand;
        end
    end

    assign signed_sel = bus.Signed_Mode;
`else
    assign add_res    = ext_acc + ext_mcand;
    assign signed_sel = 1'b0;

    logic signed_mode_unused;
    assign signed_mode_unused = bus.Signed_Mode;
`endif

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        q_d       = q_q;
        x_d       = x_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        product_d = product_q;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    mcand_d = bus.A;
                    q_d     = bus.B;
                    acc_d   = '0;
                    x_d     = 1'b0;
                    cnt_d   = '0;
                    sgn_d   = signed_sel;
                    state_d = S_ADD;
                end
            end

            S_ADD: begin
                busy = 1'b1;
                if (q_q[0]) begin
                    {x_d, acc_d} = add_res;
                end
                state_d = S_SHIFT;
            end

            S_SHIFT: begin
                busy = 1'b1;
                // {X,Acc,Q} >> 1. X is kept as the sign in signed mode and
                // cleared in unsigned mode.
                x_d   = sgn_q & x_q;
                acc_d = {x_q, acc_q[WIDTH-1:1]};
                q_d   = {acc_q[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    // Same value as {acc_d, q_d}, written out so the
                    // product does not depend on the shifted registers.
                    product_d = {x_q, acc_q, q_q[WIDTH-1:1]};
                    state_d   = S_DONE;
                end else begin
                    state_d = S_ADD;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            x_q       <= 1'b0;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            x_q       <= x_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            product_q <= product_d;
        end
    end

    assign bus.Busy    = busy;
    assign bus.Done    = done;
    assign bus.Product = product_q;
    assign dbg_state_o = state_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_busy_done_exclusive: assert property (
        @(posedge Clk) disable iff (Reset) !(bus.Busy && bus.Done)
    );

    a_product_stable: assert property (
        @(posedge Clk) disable iff (Reset)
        (state_q != S_SHIFT || cnt_q != LAST_CNT) |=> $stable(bus.Product)
    );

endmodule
